rtc_bus_sequencer: RTL and testbench

- Responder to the general control FSM.
- Consumes its 2-bit Control mode and 1-cycle sync pulse, and executes the matching access sequence on the RTC's multiplexed address/data parallel bus.
- Modes: Init, Read (Lectura), Write (Escritura), Status write (M_S).
- Read results come back to the datapath as one 72-bit word with a valid strobe.

---
 rtl/rtc_bus_sequencer_if.sv | 26 ++
 rtl/rtc_bus_sequencer.sv | 96 +++++++++
 tb/tb_rtc_bus_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_sequencer_if.sv
// rtc_bus_sequencer_if: command inputs from the control FSM plus the RTC multiplexed bus and read-back word.
interface rtc_bus_sequencer_if;
    logic [1:0]  Control;
    logic        sync;
    logic [71:0] wr_data;
    logic [2:0]  status3;
    logic [7:0]  dato_in;
    logic [7:0]  dato_out;
    logic        dato_oe;
    logic        CS_n;
    logic        RD_n;
    logic        WR_n;
    logic        AD;
    logic [71:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    modport slave (
        input  Control, sync, wr_data, status3, dato_in,
        output dato_out, dato_oe, CS_n, RD_n, WR_n, AD, rd_data, rd_valid, busy, done
    );
    modport master (
        output Control, sync, wr_data, status3, dato_in,
        input  dato_out, dato_oe, CS_n, RD_n, WR_n, AD, rd_data, rd_valid, busy, done
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: runs Init/Read/Write/Status access sequences on the RTC multiplexed address/data bus.
module rtc_bus_sequencer #(
    parameter int         PHASE_CYC = 2,
    parameter logic [7:0] INIT_CTRL = 8'hD2
) (
    input logic reloj,
    input logic resetM,
    rtc_bus_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR_STB = 3'd1;
    localparam logic [2:0] ADDR_GAP = 3'd2;
    localparam logic [2:0] DATA_STB = 3'd3;
    localparam logic [2:0] DATA_GAP = 3'd4;
    localparam logic [2:0] SEP      = 3'd5;
    localparam logic [2:0] FIN      = 3'd6;
    localparam logic [1:0] M_I = 2'b00;
    localparam logic [1:0] M_L = 2'b01;
    localparam logic [1:0] M_S = 2'b11;
    localparam logic [71:0] REG_ADDRS = 72'h43_42_41_26_25_24_23_22_21;

    logic [2:0]  state;
    logic [3:0]  cnt, idx, len;
    logic [1:0]  op, pend_mode, next_mode;
    logic        pend_valid, launch, last_cyc, seq_end, in_acc, is_rd;
    logic [71:0] wr_snap, shadow, rd_q;
    logic [2:0]  st_snap;
    logic [7:0]  addr, data;

    assign last_cyc  = cnt == 4'(PHASE_CYC - 1);
    assign len       = op == M_I ? 4'd3 : op == M_S ? 4'd1 : 4'd9;
    assign seq_end   = idx + 4'd1 >= len;
    // a queued command may start straight out of FIN, so busy never drops between them
    assign launch    = (state == IDLE || state == FIN) && (bus.sync || pend_valid);
    assign next_mode = bus.sync ? bus.Control : pend_mode;

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            state      <= IDLE;
            op         <= M_I;
            cnt        <= 4'd0;
            idx        <= 4'd0;
            pend_valid <= 1'b0;
            pend_mode  <= M_I;
            wr_snap    <= 72'd0;
            st_snap    <= 3'd0;
            shadow     <= 72'd0;
            rd_q       <= 72'd0;
        end else if (launch) begin
            state      <= ADDR_STB;
            op         <= next_mode;
            cnt        <= 4'd0;
            idx        <= 4'd0;
            pend_valid <= 1'b0;
            wr_snap    <= bus.wr_data;
            st_snap    <= bus.status3;
        end else begin
            if (bus.sync) begin
                pend_valid <= 1'b1;
                pend_mode  <= bus.Control;
            end
            case (state)
                ADDR_STB, ADDR_GAP, DATA_STB, DATA_GAP: begin
                    cnt <= last_cyc ? 4'd0 : cnt + 4'd1;
                    if (last_cyc) state <= state + 3'd1;
                    if (state == DATA_STB && last_cyc && op == M_L) shadow[{idx, 3'b000} +: 8] <= bus.dato_in;
                end
                SEP: begin
                    idx   <= seq_end ? len : idx + 4'd1;
                    state <= seq_end ? FIN : ADDR_STB;
                    if (seq_end && op == M_L) rd_q <= shadow;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign addr = op == M_I ? (idx == 4'd2 ? 8'h10 : 8'h02) :
                  op == M_S ? 8'h00 : REG_ADDRS[{idx, 3'b000} +: 8];
    assign data = op == M_I ? (idx == 4'd0 ? 8'h10 : idx == 4'd1 ? 8'h00 : INIT_CTRL) :
                  op == M_S ? {5'b0, st_snap} : wr_snap[{idx, 3'b000} +: 8];

    assign in_acc       = state >= ADDR_STB && state <= DATA_GAP;
    assign is_rd        = op == M_L;
    assign bus.CS_n     = !in_acc;
    assign bus.AD       = state == DATA_STB || state == DATA_GAP;
    assign bus.WR_n     = !(state == ADDR_STB || (state == DATA_STB && !is_rd));
    assign bus.RD_n     = !(state == DATA_STB && is_rd);
    assign bus.dato_oe  = state == ADDR_STB || state == ADDR_GAP || (state == DATA_STB && !is_rd);
    assign bus.dato_out = (state == ADDR_STB || state == ADDR_GAP) ? addr :
                          (state == DATA_STB && !is_rd) ? data : 8'h00;
    assign bus.rd_data  = rd_q;
    assign bus.rd_valid = state == FIN && is_rd;
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == FIN;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed checks of reset, the four sequences, bus timing and command queueing.
module tb_rtc_bus_sequencer;
    logic reloj = 1'b0;
    logic resetM = 1'b0;
    rtc_bus_sequencer_if bus();

    rtc_bus_sequencer #(.PHASE_CYC(2), .INIT_CTRL(8'hD2)) dut (
        .reloj (reloj),
        .resetM(resetM),
        .bus   (bus)
    );

    always #5 reloj = ~reloj;

    int passed = 0;
    int total  = 0;
    int cyc;
    int windows = 0;
    int rd_low  = 0;
    int rv_cnt  = 0;
    logic [7:0] seq_acc = 8'h00;
    logic [7:0] cur_addr = 8'h00;
    logic prev_cs = 1'b1;
    logic prev_wr = 1'b1;
    logic [15:0] wr_log[$];
    logic [7:0] exp_addr[9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    // bus model: answers reads with 0x10+k and logs every (address, data) write pair
    always @(posedge reloj) begin
        #1;
        if (prev_cs && !bus.CS_n) begin
            bus.dato_in = 8'h10 + seq_acc;
            seq_acc = seq_acc + 8'd1;
            windows++;
        end
        if (!bus.busy) seq_acc = 8'h00;
        if (!bus.CS_n && !bus.AD && !bus.WR_n) cur_addr = bus.dato_out;
        if (!bus.CS_n && bus.AD && !bus.WR_n && prev_wr) wr_log.push_back({cur_addr, bus.dato_out});
        if (!bus.RD_n) rd_low++;
        if (bus.rd_valid) rv_cnt++;
        prev_cs = bus.CS_n;
        prev_wr = bus.WR_n;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic launch(input logic [1:0] m);
        bus.Control = m;
        bus.sync = 1'b1;
        @(negedge reloj);
        bus.sync = 1'b0;
        cyc = 1;
        chk("start_busy", bus.busy, 1'b1);
        chk("start_cs", bus.CS_n, 1'b0);
    endtask

    task automatic wait_done(input int exp, input string tag);
        while (!bus.done && cyc < 400) begin
            @(negedge reloj);
            cyc++;
        end
        chk(tag, cyc, exp);
        @(negedge reloj);
        chk("done_pulse", bus.done, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
    endtask

    int w0, r0, v0, l0, gap, dones;

    initial begin
        bus.Control = 2'b00;
        bus.sync    = 1'b0;
        bus.wr_data = 72'd0;
        bus.status3 = 3'd0;
        bus.dato_in = 8'h00;
        repeat (2) @(negedge reloj);
        chk("rst_cs", bus.CS_n, 1'b1);
        chk("rst_wr", bus.WR_n, 1'b1);
        chk("rst_rd", bus.RD_n, 1'b1);
        chk("rst_ad", bus.AD, 1'b0);
        chk("rst_oe", bus.dato_oe, 1'b0);
        chk("rst_dout", bus.dato_out, 8'h00);
        chk("rst_rdata", bus.rd_data, 72'd0);
        chk("rst_busy_done", {bus.busy, bus.done, bus.rd_valid}, 3'b000);
        resetM = 1'b1;
        @(negedge reloj);

        // asynchronous reset in the data strobe of an E write, with a read queued
        bus.wr_data = 72'h090807060504030201;
        launch(2'b10);
        @(negedge reloj);
        bus.Control = 2'b01;
        bus.sync = 1'b1;
        @(negedge reloj);
        bus.sync = 1'b0;
        repeat (2) @(negedge reloj);
        chk("mid_ad", bus.AD, 1'b1);
        chk("mid_wr", bus.WR_n, 1'b0);
        #1 resetM = 1'b0;
        #1;
        chk("arst_wr", bus.WR_n, 1'b1);
        chk("arst_cs", bus.CS_n, 1'b1);
        chk("arst_oe", bus.dato_oe, 1'b0);
        chk("arst_busy", bus.busy, 1'b0);
        @(negedge reloj);
        resetM = 1'b1;
        repeat (3) @(negedge reloj);
        chk("no_pending_after_rst", {bus.busy, bus.CS_n}, 2'b01);

        // L: nine reads
        w0 = windows; r0 = rd_low; v0 = rv_cnt;
        launch(2'b01);
        while (!bus.done && cyc < 400) begin
            @(negedge reloj);
            cyc++;
        end
        chk("l_cycles", cyc, 82);
        chk("l_valid_with_done", bus.rd_valid, 1'b1);
        chk("l_rdata", bus.rd_data, 72'h181716151413121110);
        @(negedge reloj);
        chk("l_valid_pulse", bus.rd_valid, 1'b0);
        chk("l_windows", windows - w0, 9);
        chk("l_rd_low", rd_low - r0, 18);
        chk("l_rv_cnt", rv_cnt - v0, 1);

        // E: nine writes
        l0 = wr_log.size(); r0 = rd_low; v0 = rv_cnt;
        bus.wr_data = 72'h090807060504030201;
        launch(2'b10);
        bus.wr_data = 72'hFFFFFFFFFFFFFFFFFF;
        wait_done(82, "e_cycles");
        chk("e_count", wr_log.size() - l0, 9);
        for (int k = 0; k < 9; k++) chk($sformatf("e_pair%0d", k), wr_log[l0 + k], {exp_addr[k], 8'(k + 1)});
        chk("e_rd_quiet", rd_low - r0, 0);
        chk("e_rdata_kept", bus.rd_data, 72'h181716151413121110);
        chk("e_no_valid", rv_cnt - v0, 0);

        // I: three init writes
        l0 = wr_log.size();
        launch(2'b00);
        wait_done(28, "i_cycles");
        chk("i_count", wr_log.size() - l0, 3);
        chk("i_pair0", wr_log[l0], 16'h0210);
        chk("i_pair1", wr_log[l0 + 1], 16'h0200);
        chk("i_pair2", wr_log[l0 + 2], 16'h10D2);

        // L with M_S then E queued: last command wins, busy never drops
        l0 = wr_log.size(); v0 = rv_cnt; gap = 0; dones = 0;
        bus.wr_data = 72'h998877665544332211;
        launch(2'b01);
        while (dones < 2 && cyc < 400) begin
            @(negedge reloj);
            cyc++;
            bus.sync = 1'b0;
            if (cyc == 10) begin bus.Control = 2'b11; bus.sync = 1'b1; end
            if (cyc == 30) begin bus.Control = 2'b10; bus.sync = 1'b1; end
            if (!bus.busy) gap = 1;
            if (bus.done) dones++;
        end
        chk("q_cycles", cyc, 164);
        chk("q_busy_gap", gap, 0);
        @(negedge reloj);
        chk("q_idle", bus.busy, 1'b0);
        chk("q_rv_once", rv_cnt - v0, 1);
        chk("q_wr_count", wr_log.size() - l0, 9);
        chk("q_first", wr_log[l0], 16'h2111);
        chk("q_last", wr_log[l0 + 8], 16'h4399);
        chk("q_rdata", bus.rd_data, 72'h181716151413121110);

        // M_S: status snapshot at start
        l0 = wr_log.size();
        bus.status3 = 3'b101;
        launch(2'b11);
        bus.status3 = 3'b010;
        wait_done(10, "m_cycles");
        chk("m_count", wr_log.size() - l0, 1);
        chk("m_pair", wr_log[l0], 16'h0005);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
